memmap_io: RTL and testbench
============================

# memmap_io

Parametrised successor to the processor memory-mapped I/O block. It provides a general read/write word store plus dedicated peripheral windows: a buffered PS/2 receive FIFO with status/overflow reporting, and a double-buffered VGA output word with an optional vsync-synchronised commit. It sits between the CPU load/store path and the PS/2 and VGA controllers.

## Interface
- DATA_W, 32, word width of all data paths
- ADDR_W, 6, width of `dir`; the top four addresses are reserved for I/O
- NUM_REGS, 32, general storage words at addresses 0..NUM_REGS-1; legal when NUM_REGS ≤ 2^ADDR_W − 4
- FIFO_DEPTH, 8, PS/2 FIFO entries; power of two, ≥ 2
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- dir  in  ADDR_W  word address
- dataWrite  in  DATA_W  CPU write data
- WE  in  1  write strobe, one write per cycle
- RE  in  1  read strobe; side-effect qualifier, used only by the PS/2 pop
- dataForPS2  in  DATA_W  PS/2 received word
- ps2Valid  in  1  one-cycle push strobe for `dataForPS2`
- vsync  in  1  frame-boundary pulse from the VGA controller
- readData  out  DATA_W  combinational read data for `dir`
- dataForVGA  out  DATA_W  committed VGA word
- ps2Irq  out  1  high while the FIFO is non-empty

## Operation
- Address map, with T = 2^ADDR_W:
  - 0..NUM_REGS-1: RAM. Writes are stored. Reads return the stored word.
  - T−4: VGA_CTRL. Bit 0 is SYNC_MODE and is read/write; all other bits read 0.
  - T−3: PS2_STAT. Read layout: [1:0] = {full, empty}, [2] = overflow (sticky), [3+:log2(FIFO_DEPTH)+1] = count. Any write clears overflow.
  - T−2: PS2_DATA. Read returns the FIFO head, or 0 when the FIFO is empty. A read with `RE`=1 pops one entry. Writes are ignored.
  - T−1: VGA_DATA. A write loads the staging register. A read returns the staging register.
  - Unmapped addresses read 0 and ignore writes.
- PS/2 FIFO:
  - `ps2Valid`=1 pushes `dataForPS2`.
  - A push when full drops the data and sets overflow. The FIFO contents are unchanged.
  - A pop when empty is ignored.
  - Push and pop in the same cycle when not empty: both occur and count is unchanged.
  - Push and pop in the same cycle when full: both occur, nothing is dropped, and overflow is not set.
  - Push and pop in the same cycle when empty: the push occurs and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count ranges 0..FIFO_DEPTH.
- VGA commit:
  - SYNC_MODE=0: `dataForVGA` takes the staging value on the edge after the staging register changes. Functionally the output follows the staging register with a one-cycle delay.
  - SYNC_MODE=1: `dataForVGA` loads the staging register only on edges where `vsync`=1.
  - A VGA_DATA write and `vsync` in the same cycle: the commit uses the old staging value. The new value commits on the next `vsync`.
- `ps2Irq` = !empty, derived combinationally from registered state.

## Timing
- Reset (synchronous, checked on the rising edge):
  - RAM cleared to 0.
  - FIFO emptied.
  - overflow, SYNC_MODE, staging register and `dataForVGA` all cleared to 0.
  - `ps2Irq`=0.
  - `readData` therefore reads 0 for every address.
- `reset` has priority over `WE`, `RE` and `ps2Valid` in the same cycle. Any in-flight push or pop is discarded.
- Writes take effect at the edge. A read of the same address in the following cycle returns the new value.
- `readData` is combinational from `dir` and the current state; there is zero cycle latency.
- PS/2 push latency is 1 cycle: data pushed at edge k is visible at PS2_DATA and `ps2Irq`=1 after edge k.
- Pop: the head shown during the `RE` cycle is the value consumed. The next entry appears after the edge.
- Overflow is set at the edge of the dropped push. A clear write and a dropping push in the same cycle leave overflow=1.
- VGA commit latency:
  - SYNC_MODE=0: 2 edges from the write cycle to the output.
  - SYNC_MODE=1: first `vsync` edge after the write edge.

## Test plan
- Reset: hold `reset`=1 for 3 cycles with `WE`=1, `dir`=1 → `readData`=0, `dataForVGA`=0, `ps2Irq`=0; RAM[1] remains 0.
- RAM: write 0xFFFF_FFF0 to `dir`=1, then write 0x1234_5678 to `dir`=NUM_REGS-1 → each reads back exactly; `dir`=NUM_REGS (if unmapped) reads 0 after a write.
- PS/2 FIFO:
  - Push 0xFFAF_AFF0, then 0x0000_001C.
  - PS2_DATA reads 0xFFAF_AFF0 and count is 2.
  - Pop once → PS2_DATA reads 0x1C.
  - Pop again → `ps2Irq`=0 and PS2_DATA reads 0.
- Overflow:
  - Push FIFO_DEPTH+1 words (values 1..9 with DEPTH=8) → full=1, overflow=1, and the pop sequence is 1..8.
  - Write PS2_STAT → overflow=0.
  - Simultaneous push and pop when full → count stays 8 and overflow stays 0.
- VGA:
  - SYNC_MODE=0: write 0xA5A5_0001 → `dataForVGA` equals it 2 edges later.
  - Set SYNC_MODE=1 and write 0x0000_00FF → output holds 0xA5A5_0001 until the `vsync` edge, then shows 0xFF.
- Simultaneity: VGA_DATA write and `vsync` in the same cycle (SYNC_MODE=1) → the old staging value commits and the new value commits on the next `vsync`. `reset` asserted during a push → FIFO empty afterwards.

Source files
------------

// File: rtl/memmap_io.sv
// Memory-mapped I/O block: general word store, buffered PS/2 receive FIFO with
// status/overflow reporting, and a double-buffered VGA output word.
module memmap_io #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] dir,
    input  logic [DATA_W-1:0] dataWrite,
    input  logic              WE,
    input  logic              RE,
    input  logic [DATA_W-1:0] dataForPS2,
    input  logic              ps2Valid,
    input  logic              vsync,
    output logic [DATA_W-1:0] readData,
    output logic [DATA_W-1:0] dataForVGA,
    output logic              ps2Irq
);

    localparam int unsigned TOP    = 2 ** ADDR_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned RAM_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [ADDR_W-1:0] A_VGA_CTRL = ADDR_W'(TOP - 4);
    localparam logic [ADDR_W-1:0] A_PS2_STAT = ADDR_W'(TOP - 3);
    localparam logic [ADDR_W-1:0] A_PS2_DATA = ADDR_W'(TOP - 2);
    localparam logic [ADDR_W-1:0] A_VGA_DATA = ADDR_W'(TOP - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);

    // Storage
    logic [DATA_W-1:0] r_ram  [NUM_REGS];
    logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_sync_mode;
    logic [DATA_W-1:0] r_stage;
    logic [DATA_W-1:0] r_vga;

    // Decode and FIFO control
    logic              w_ram_hit;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_stat_clr;
    logic [DATA_W-1:0] w_read;

    assign w_ram_hit  = (32'(dir) < NUM_REGS);
    assign w_ram_idx  = RAM_AW'(dir);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_FULL);
    assign w_pop      = RE && (dir == A_PS2_DATA) && !w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
    assign w_push     = ps2Valid && (!w_full || w_pop);
    assign w_drop     = ps2Valid && w_full && !w_pop;
    assign w_stat_clr = WE && (dir == A_PS2_STAT);

    // General word store
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_ram[i] <= '0;
            end
        end else if (WE && w_ram_hit) begin
            r_ram[w_ram_idx] <= dataWrite;
        end
    end

    // FIFO payload; contents past the read pointer are never exposed, so no reset
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_fifo[r_wr_ptr] <= dataForPS2;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a dropped push wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_stat_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // VGA staging and commit; commit always samples the pre-edge staging value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_mode <= 1'b0;
            r_stage     <= '0;
            r_vga       <= '0;
        end else begin
            if (WE && (dir == A_VGA_CTRL)) begin
                r_sync_mode <= dataWrite[0];
            end
            if (WE && (dir == A_VGA_DATA)) begin
                r_stage <= dataWrite;
            end
            if (!r_sync_mode || vsync) begin
                r_vga <= r_stage;
            end
        end
    end

    // Zero-latency read mux
    always_comb begin
        w_read = '0;
        if (w_ram_hit) begin
            w_read = r_ram[w_ram_idx];
        end else begin
            case (dir)
                A_VGA_CTRL: w_read = DATA_W'(r_sync_mode);
                A_PS2_STAT: w_read = DATA_W'({r_count, r_ovf, w_full, w_empty});
                A_PS2_DATA: begin
                    if (!w_empty) begin
                        w_read = r_fifo[r_rd_ptr];
                    end
                end
                A_VGA_DATA: w_read = r_stage;
                default:    w_read = '0;
            endcase
        end
    end

    assign readData   = w_read;
    assign dataForVGA = r_vga;
    assign ps2Irq     = !w_empty;

endmodule

// File: tb/tb_memmap_io.sv
// Directed and randomized bench for memmap_io against a queue/array reference model.
module tb_memmap_io;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int NREGS = 32;
    localparam int DEPTH = 8;
    localparam int T     = 2 ** AW;

    localparam logic [AW-1:0] A_CTRL  = AW'(T - 4);
    localparam logic [AW-1:0] A_STAT  = AW'(T - 3);
    localparam logic [AW-1:0] A_PDATA = AW'(T - 2);
    localparam logic [AW-1:0] A_VDATA = AW'(T - 1);

    logic          clk;
    logic          reset;
    logic [AW-1:0] dir;
    logic [DW-1:0] dataWrite;
    logic          WE;
    logic          RE;
    logic [DW-1:0] dataForPS2;
    logic          ps2Valid;
    logic          vsync;
    logic [DW-1:0] readData;
    logic [DW-1:0] dataForVGA;
    logic          ps2Irq;

    memmap_io #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NREGS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .dir(dir), .dataWrite(dataWrite),
        .WE(WE), .RE(RE), .dataForPS2(dataForPS2), .ps2Valid(ps2Valid),
        .vsync(vsync), .readData(readData), .dataForVGA(dataForVGA),
        .ps2Irq(ps2Irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] m_ram [NREGS];
    logic [DW-1:0] m_q [$];
    logic          m_ovf;
    logic          m_sync;
    logic [DW-1:0] m_stage;
    logic [DW-1:0] m_vga;
    logic          m_valid = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        int n;
        n = m_q.size();
        if (int'(a) < NREGS) return m_ram[int'(a)];
        if (a == A_CTRL)  return DW'(m_sync);
        if (a == A_STAT)  return DW'(n * 8 + (m_ovf ? 4 : 0) + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0));
        if (a == A_PDATA) return (n > 0) ? m_q[0] : '0;
        if (a == A_VDATA) return m_stage;
        return '0;
    endfunction

    // Model update for one rising edge, using the inputs held across it
    task automatic apply_edge();
        int  n;
        bit  pop;
        bit  drop;
        if (reset) begin
            for (int i = 0; i < NREGS; i++) m_ram[i] = '0;
            m_q.delete();
            m_ovf   = 1'b0;
            m_sync  = 1'b0;
            m_stage = '0;
            m_vga   = '0;
            m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        if (!m_sync || vsync) m_vga = m_stage;
        n    = m_q.size();
        pop  = RE && (dir == A_PDATA) && (n > 0);
        drop = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (ps2Valid) begin
            if (n < DEPTH || pop) m_q.push_back(dataForPS2);
            else drop = 1'b1;
        end
        if (WE) begin
            if (int'(dir) < NREGS) m_ram[int'(dir)] = dataWrite;
            else if (dir == A_CTRL) m_sync = dataWrite[0];
            else if (dir == A_STAT) m_ovf = 1'b0;
            else if (dir == A_VDATA) m_stage = dataWrite;
        end
        if (drop) m_ovf = 1'b1;
    endtask

    // Check model against DUT, then advance one clock (entered/left at negedge)
    task automatic tick();
        #1;
        if (m_valid) begin
            chk("model_read", readData, exp_read(dir));
            chk("model_vga", dataForVGA, m_vga);
            chk("model_irq", {31'b0, ps2Irq}, 32'(m_q.size() != 0));
        end
        @(posedge clk);
        apply_edge();
        @(negedge clk);
    endtask

    task automatic chk_rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
        dir = a;
        #1;
        chk(tag, readData, e);
    endtask

    task automatic idle();
        reset = 1'b0; WE = 1'b0; RE = 1'b0; ps2Valid = 1'b0; vsync = 1'b0;
    endtask

    initial begin
        idle();
        dir = '0; dataWrite = '0; dataForPS2 = '0;
        @(negedge clk);

        // Reset held with a write pending to RAM[1]
        reset = 1'b1; WE = 1'b1; dir = AW'(1); dataWrite = 32'hDEAD_BEEF;
        ps2Valid = 1'b1; dataForPS2 = 32'h55;
        repeat (3) tick();
        idle();
        chk_rd("rst_ram1", AW'(1), 32'h0);
        chk("rst_vga", dataForVGA, 32'h0);
        chk("rst_irq", {31'b0, ps2Irq}, 32'h0);

        // RAM write/readback and unmapped address
        WE = 1'b1; dir = AW'(1); dataWrite = 32'hFFFF_FFF0; tick();
        dir = AW'(NREGS - 1); dataWrite = 32'h1234_5678; tick();
        WE = 1'b0;
        chk_rd("ram_1", AW'(1), 32'hFFFF_FFF0);
        chk_rd("ram_last", AW'(NREGS - 1), 32'h1234_5678);
        WE = 1'b1; dir = AW'(NREGS); dataWrite = 32'hAAAA_5555; tick();
        WE = 1'b0;
        chk_rd("unmapped", AW'(NREGS), 32'h0);
        tick();

        // PS/2 push two, pop two
        ps2Valid = 1'b1; dataForPS2 = 32'hFFAF_AFF0; tick();
        dataForPS2 = 32'h0000_001C; tick();
        ps2Valid = 1'b0;
        chk_rd("fifo_head", A_PDATA, 32'hFFAF_AFF0);
        chk_rd("fifo_stat2", A_STAT, 32'h10);
        chk("fifo_irq1", {31'b0, ps2Irq}, 32'h1);
        dir = A_PDATA; RE = 1'b1; tick();
        RE = 1'b0;
        chk_rd("fifo_pop1", A_PDATA, 32'h1C);
        RE = 1'b1; tick();
        RE = 1'b0;
        chk("fifo_irq0", {31'b0, ps2Irq}, 32'h0);
        chk_rd("fifo_empty_rd", A_PDATA, 32'h0);

        // Overflow: DEPTH+1 pushes, then drain in order
        for (int i = 1; i <= DEPTH + 1; i++) begin
            ps2Valid = 1'b1; dataForPS2 = DW'(i); tick();
        end
        ps2Valid = 1'b0;
        chk_rd("ovf_stat", A_STAT, 32'h46);
        for (int i = 1; i <= DEPTH; i++) begin
            chk_rd("ovf_pop_seq", A_PDATA, DW'(i));
            RE = 1'b1; tick();
            RE = 1'b0;
        end
        WE = 1'b1; dir = A_STAT; dataWrite = 32'h0; tick();
        WE = 1'b0;
        chk_rd("ovf_clear", A_STAT, 32'h01);

        // Full FIFO with simultaneous push and pop
        for (int i = 1; i <= DEPTH; i++) begin
            ps2Valid = 1'b1; dataForPS2 = DW'(32'h100 + i); tick();
        end
        ps2Valid = 1'b1; dataForPS2 = 32'h99; dir = A_PDATA; RE = 1'b1; tick();
        ps2Valid = 1'b0; RE = 1'b0;
        chk_rd("full_pushpop_stat", A_STAT, 32'h42);
        chk_rd("full_pushpop_head", A_PDATA, 32'h102);
        // Clear write racing a dropped push leaves overflow set
        WE = 1'b1; dir = A_STAT; ps2Valid = 1'b1; dataForPS2 = 32'hBAD; tick();
        WE = 1'b0; ps2Valid = 1'b0;
        chk_rd("clr_vs_drop", A_STAT, 32'h46);

        // VGA immediate mode: two edges from write cycle
        WE = 1'b1; dir = A_VDATA; dataWrite = 32'hA5A5_0001; tick();
        WE = 1'b0;
        chk("vga_edge1", dataForVGA, 32'h0);
        tick();
        chk("vga_edge2", dataForVGA, 32'hA5A5_0001);

        // VGA sync mode
        WE = 1'b1; dir = A_CTRL; dataWrite = 32'hFFFF_FFFF; tick();
        dir = A_VDATA; dataWrite = 32'h0000_00FF; tick();
        WE = 1'b0;
        chk_rd("ctrl_rd", A_CTRL, 32'h1);
        chk_rd("stage_rd", A_VDATA, 32'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("vga_hold", dataForVGA, 32'hA5A5_0001);
        end
        vsync = 1'b1; tick();
        vsync = 1'b0;
        chk("vga_vsync", dataForVGA, 32'hFF);

        // Staging write coinciding with vsync commits the old value
        WE = 1'b1; dir = A_VDATA; dataWrite = 32'h77; vsync = 1'b1; tick();
        WE = 1'b0; vsync = 1'b0;
        chk("vga_same_cycle", dataForVGA, 32'hFF);
        tick();
        chk("vga_wait", dataForVGA, 32'hFF);
        vsync = 1'b1; tick();
        vsync = 1'b0;
        chk("vga_next_vsync", dataForVGA, 32'h77);

        // Reset during a push
        reset = 1'b1; ps2Valid = 1'b1; dataForPS2 = 32'h5; tick();
        idle();
        chk("rst_push_irq", {31'b0, ps2Irq}, 32'h0);
        chk_rd("rst_push_stat", A_STAT, 32'h01);
        chk("rst_push_vga", dataForVGA, 32'h0);

        // Randomized traffic checked against the model
        for (int c = 0; c < 2000; c++) begin
            int sel;
            reset      = ($urandom_range(127) == 0);
            WE         = ($urandom_range(2) == 0);
            RE         = ($urandom_range(1) == 0);
            ps2Valid   = ($urandom_range(3) == 0);
            vsync      = ($urandom_range(7) == 0);
            dataWrite  = $urandom;
            dataForPS2 = $urandom;
            sel = int'($urandom_range(7));
            if (sel < 3)      dir = A_PDATA;
            else if (sel < 5) dir = AW'(T - 4 + int'($urandom_range(3)));
            else              dir = AW'($urandom_range(T - 1));
            tick();
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
